// File: rtl/seq_mul32_ctrl.sv
// Iterative 32x32->64 unsigned shift-and-add multiplier around one shared 32-bit adder.
// Optional early termination when the remaining multiplier bits are zero: SEQ_MUL_EARLY_EXIT_EN.
module seq_mul32_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] product,
   output logic        busy
);

   localparam int unsigned OP_W   = 32;
   localparam int unsigned PROD_W = 64;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned SH_W   = 7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [OP_W-1:0]     r_mcand;
   logic [OP_W-1:0]     r_hi;
   logic [OP_W-1:0]     r_lo;
   logic [CNT_W-1:0]    r_cnt;
   logic [PROD_W-1:0]   r_product;

   logic [OP_W-1:0]     w_addend;
   logic [OP_W-1:0]     w_sum;
   logic                w_cout;
   logic [PROD_W-1:0]   w_shifted;
   logic                w_last;
   logic                w_exit;

   // Shared adder: partial product high half plus the gated multiplicand.
   assign w_addend           = r_lo[0] ? r_mcand : '0;
   assign {w_cout, w_sum}    = {1'b0, r_hi} + {1'b0, w_addend};
   assign w_shifted          = {w_cout, w_sum, r_lo[OP_W-1:1]};
   assign w_last             = (r_cnt == CNT_W'(OP_W - 1));

`ifdef SEQ_MUL_EARLY_EXIT_EN
   logic                w_rem_zero;
   logic [PROD_W-1:0]   w_early_prod;

   // Low (32-k) bits of lo still hold unconsumed multiplier bits.
   assign w_rem_zero   = ((r_lo & ({OP_W{1'b1}} >> r_cnt)) == '0);
   assign w_early_prod = {r_hi, r_lo} >> (SH_W'(OP_W) - SH_W'(r_cnt));
   assign w_exit       = w_last | w_rem_zero;
`else
   assign w_exit       = w_last;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
         S_RUN:   if (w_exit)    w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand capture, shift-add iteration and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_mcand <= a;
                  r_hi    <= '0;
                  r_lo    <= b;
                  r_cnt   <= '0;
               end
            end
            S_RUN: begin
               {r_hi, r_lo} <= w_shifted;
               r_cnt        <= r_cnt + CNT_W'(1);
`ifdef SEQ_MUL_EARLY_EXIT_EN
               if (w_rem_zero)  r_product <= w_early_prod;
               else if (w_last) r_product <= w_shifted;
`else
               if (w_last)      r_product <= w_shifted;
`endif
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state == S_RUN);
   assign out_valid = (r_state == S_DONE);
   assign product   = r_product;

endmodule

// File: doc/seq_mul32_ctrl.md
# seq_mul32_ctrl

Iterative 32×32 → 64-bit unsigned multiplier controller that sequences a single shared 32-bit parallel-prefix adder (x, y, cIn → s, cOut) through a radix-2 shift-and-add loop. It sits beside the array multiplier as the low-area multiply path. Operands are accepted and results returned over valid/ready handshakes, one operation in flight at a time.

## Interface
- No parameters; widths fixed at 32-bit operands and a 64-bit product.
- `clk` — input, 1 — sole clock; all state updates on the rising edge.
- `rst_n` — input, 1 — reset, asynchronous, active-low.
- `in_valid` — input, 1 — operand pair valid.
- `in_ready` — output, 1 — block can accept operands; high only in IDLE.
- `a` — input, 32 — multiplicand, unsigned.
- `b` — input, 32 — multiplier, unsigned.
- `out_valid` — output, 1 — `product` valid; high only in DONE.
- `out_ready` — input, 1 — consumer accepts `product`.
- `product` — output, 64 — `a*b`, registered.
- `busy` — output, 1 — high in RUN.

## Operation
- Registers:
  - `mcand[31:0]`
  - `hi[31:0]`
  - `lo[31:0]`
  - `cnt[5:0]`
  - `product[63:0]`
  - `state`
- Adder hookup: x = `hi`, y = `lo[0] ? mcand : 0`, cIn = 0, giving `{cOut, s}`.
- States are IDLE, RUN and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: `mcand`←`a`, `hi`←0, `lo`←`b`, `cnt`←0, go to RUN.
- RUN, each cycle:
  - `{hi, lo}` ← `{cOut, s, lo[31:1]}`.
  - `cnt`←`cnt`+1.
  - When `cnt`==31, `product`←the shifted `{cOut, s, lo[31:1]}` and go to DONE.
- DONE:
  - `out_valid`=1; `product` is held stable.
  - On `out_ready`, go to IDLE.
- Arithmetic rules:
  - `cOut` is the 33rd bit and is never dropped.
  - Intermediate `{hi, lo}` never exceeds 64 bits.
  - Result is exact for all inputs, including `a` = `b` = 0xFFFFFFFF.
- Boundary conditions:
  - `in_valid` outside IDLE is ignored and operands are not sampled; the source must hold them.
  - `out_ready` outside DONE is ignored.
  - `out_ready` may be held high permanently.
- Reset (also mid-RUN or mid-DONE):
  - Immediately forces IDLE.
  - `product`=0, `hi`=`lo`=`mcand`=0, `cnt`=0.
  - The in-flight operation is discarded and no `out_valid` is produced for it.
- Reset output values:
  - `in_ready`=1
  - `out_valid`=0
  - `busy`=0
  - `product`=0

## Timing
- Accept edge E0 is the edge where `in_valid` && `in_ready`.
- RUN occupies the 32 cycles after E0.
- `out_valid` rises after edge E32, i.e. fixed latency of 32 cycles from accept to result.
- The result handshake edge returns the block to IDLE.
- `in_ready` is high on the next cycle, so minimum initiation interval is 34 cycles (32 RUN + 1 DONE + 1 IDLE).
- `in_ready`, `out_valid` and `busy` decode from `state` only; no combinational path from inputs to outputs.
- The adder is the only multi-level combinational path; it is registered every cycle.

## Configuration
- `SEQ_MUL_EARLY_EXIT_EN` defined:
  - In a RUN cycle with count k, if the unconsumed multiplier bits `lo[31-k:0]` are all zero, `product`←`{hi, lo}` >> (32−k) and the block goes to DONE that cycle without using the adder result.
  - Latency is h+2 cycles, where h is the index of the highest set bit of `b`, capped at 32.
  - `b`=0 gives latency 1.
  - Products are identical to the fixed-latency build.
- Macro undefined: latency is always 32 cycles and the early-exit logic is not synthesized.

## Test plan
- Reset sequencing: assert `rst_n`=0 mid-RUN (cycle 10) → `out_valid`=0, `product`=0, `in_ready`=1 immediately; next accept of 3×5 → `product`=15.
- Maximum operands: `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → `product`=0xFFFFFFFE00000001, `out_valid` exactly 32 cycles after accept.
- Back-pressure: `a`=0x12345678, `b`=0x9ABCDEF0, `out_ready`=0 for 20 cycles → `product`=0x0B00EA4E242D2080 held stable; `in_valid` pulses during RUN/DONE are ignored.
- Zero and one: `b`=0 → `product`=0; `a`=0xDEADBEEF, `b`=1 → `product`=0x00000000DEADBEEF. With `SEQ_MUL_EARLY_EXIT_EN`, latencies are 1 and 2 cycles; without it, 32 cycles.
- Throughput: 1000 random pairs, `in_valid` and `out_ready` always high → every product matches the reference model, with accepts spaced 34 cycles apart in the fixed-latency build.
